// File: rtl/alu_decode_stage_if.sv
// Decode-to-execute handshake bundle for alu_decode_stage.
// slave  : the decode stage itself (consumes decode fields, produces controls)
// master : whoever drives decode fields and consumes controls
interface alu_decode_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic       op5;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       funct7_4;
    logic       funct7_0;
    logic [1:0] ALUOp;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] ALUControl;
    logic [2:0] load_store;
    logic       mdu_busy;

    modport slave (
        input  in_valid, op5, funct3, funct7_5, funct7_4, funct7_0, ALUOp, out_ready,
        output in_ready, out_valid, ALUControl, load_store, mdu_busy
    );

    modport master (
        output in_valid, op5, funct3, funct7_5, funct7_4, funct7_0, ALUOp, out_ready,
        input  in_ready, out_valid, ALUControl, load_store, mdu_busy
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage with valid/ready flow control.
// Optional feature macro: ALU_DECODE_RV32M_EN -- builds RV32M decode and the
// WAIT state with its latency counter. Without it every accepted op reaches
// HOLD after one edge and mdu_busy is tied low.
module alu_decode_stage #(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    alu_decode_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [4:0] ctrl_q, dec_ctrl;
    logic [2:0] ls_q, dec_ls;
    logic       w75, w74;
    logic       in_ready, accept, load;

`ifdef ALU_DECODE_RV32M_EN
    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    // Counter preload is latency-2: WAIT is entered on the accept edge and
    // HOLD is entered on the edge after the counter reads zero.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_LATENCY > 1) ? DIV_LATENCY - 2 : 0);
    localparam bit MUL_MULTI = (MUL_LATENCY > 1);
    localparam bit DIV_MULTI = (DIV_LATENCY > 1);

    logic [CNT_W-1:0] cnt, cnt_n, dec_cnt;
    logic             dec_multi;
`else
    // funct7_0 only matters for M-class decode
    logic unused_f70;
    assign unused_f70 = bus.funct7_0;
`endif

    // Field decode of the presented op; only sampled into registers at accept
    always_comb begin
        w75      = bus.funct7_5 & bus.op5;
        w74      = bus.funct7_4 & bus.op5;
        dec_ctrl = 5'b00000;
        dec_ls   = 3'b000;
        case (bus.ALUOp)
            2'b00: begin
                case (bus.funct3)
                    3'b000:  dec_ls = 3'b001;
                    3'b001:  dec_ls = 3'b010;
                    3'b100:  dec_ls = 3'b011;
                    3'b101:  dec_ls = 3'b100;
                    default: dec_ls = 3'b000;
                endcase
            end
            2'b01: dec_ctrl = 5'b00001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  dec_ctrl = w75 ? 5'b00001 : 5'b00000;
                    3'b001:  dec_ctrl = 5'b00010;
                    3'b010:  dec_ctrl = w74 ? 5'b01101 : 5'b00011;
                    3'b011:  dec_ctrl = 5'b00100;
                    3'b100:  dec_ctrl = w74 ? 5'b01110 : (w75 ? 5'b01100 : 5'b00101);
                    // shift-right arithmetic/logical select is raw funct7_5
                    3'b101:  dec_ctrl = {4'b0011, bus.funct7_5};
                    3'b110:  dec_ctrl = w74 ? 5'b01111 : (w75 ? 5'b01011 : 5'b01000);
                    default: dec_ctrl = w75 ? 5'b01010 : 5'b01001;
                endcase
            end
            default: ;
        endcase
`ifdef ALU_DECODE_RV32M_EN
        dec_multi = 1'b0;
        dec_cnt   = '0;
        if (bus.ALUOp == 2'b10 && bus.op5 && bus.funct7_0) begin
            dec_ctrl  = {2'b10, bus.funct3};
            dec_multi = bus.funct3[2] ? DIV_MULTI : MUL_MULTI;
            dec_cnt   = bus.funct3[2] ? DIV_CNT : MUL_CNT;
        end
`endif
    end

    // Next-state and handshake logic; flush beats any accept or transfer
    always_comb begin
        state_n  = state;
        load     = 1'b0;
`ifdef ALU_DECODE_RV32M_EN
        cnt_n    = cnt;
`endif
        in_ready = !reset && !flush &&
                   (state == IDLE || (state == HOLD && bus.out_ready));
        accept   = bus.in_valid && in_ready;
        case (state)
            HOLD: if (bus.out_ready) state_n = IDLE;
`ifdef ALU_DECODE_RV32M_EN
            WAIT: begin
                if (cnt == '0) state_n = HOLD;
                else           cnt_n   = cnt - CNT_W'(1);
            end
`endif
            default: ;
        endcase
        if (accept) begin
            load    = 1'b1;
            state_n = HOLD;
`ifdef ALU_DECODE_RV32M_EN
            if (dec_multi) begin
                state_n = WAIT;
                cnt_n   = dec_cnt;
            end
`endif
        end
        if (flush) begin
            state_n = IDLE;
`ifdef ALU_DECODE_RV32M_EN
            cnt_n   = '0;
`endif
        end
    end

    // State (and latency counter) register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
`ifdef ALU_DECODE_RV32M_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
`ifdef ALU_DECODE_RV32M_EN
            cnt   <= cnt_n;
`endif
        end
    end

    // Output control registers; only an accept updates them, flush leaves them
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= 5'b00000;
            ls_q   <= 3'b000;
        end else if (load) begin
            ctrl_q <= dec_ctrl;
            ls_q   <= dec_ls;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state == HOLD);
    assign bus.ALUControl = ctrl_q;
    assign bus.load_store = ls_q;
`ifdef ALU_DECODE_RV32M_EN
    assign bus.mdu_busy   = (state == WAIT);
`else
    assign bus.mdu_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: the driver pushes the expected
// controls and latency of every accepted op, the monitor checks every cycle.
module tb_alu_decode_stage;
    localparam int MUL_L = 2;
    localparam int DIV_L = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    alu_decode_stage_if bus();

    alu_decode_stage #(.MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] aluop;
        logic       op5;
        logic [2:0] f3;
        logic       f75;
        logic       f74;
        logic       f70;
    } fld_t;

    typedef struct {
        logic [4:0] ctrl;
        logic [2:0] ls;
        int         edge_n;   // clock edge at which the op is accepted
        int         lat;      // edges from accept until out_valid is seen
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode from the instruction-field tables
    function automatic exp_t ref_model(input fld_t f);
        exp_t e;
        int ls_map [8] = '{1, 2, 0, 0, 3, 4, 0, 0};
        int base   [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int tab5   [8] = '{1, 0, 0, 0, 12, 0, 11, 10};
        int tab4   [8] = '{0, 0, 13, 0, 14, 0, 15, 0};
        bit has5   [8] = '{1, 0, 0, 0, 1, 0, 1, 1};
        bit has4   [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        int c;
        e.ctrl = '0; e.ls = '0; e.edge_n = 0; e.lat = 1;
        c = 0;
        if (f.aluop == 2'd0) e.ls = 3'(ls_map[f.f3]);
        else if (f.aluop == 2'd1) c = 1;
        else if (f.aluop == 2'd2) begin
            c = base[f.f3];
            if (f.f3 == 3'd5) c = 6 + int'(f.f75);
            else if (f.op5 && f.f74 && has4[f.f3]) c = tab4[f.f3];
            else if (f.op5 && f.f75 && has5[f.f3]) c = tab5[f.f3];
`ifdef ALU_DECODE_RV32M_EN
            if (f.op5 && f.f70) begin
                c = 16 + int'(f.f3);
                e.lat = f.f3[2] ? DIV_L : MUL_L;
            end
`endif
        end
        e.ctrl = 5'(c);
        return e;
    endfunction

    // One cycle: apply inputs after the edge, register expectation if accepted
    task automatic drive(input logic iv, input fld_t f, input logic ordy,
                         input logic fl, input logic rs);
        exp_t e;
        @(posedge clk);
        if (flush || reset) q.delete();
        #1;
        bus.in_valid  = iv;
        bus.ALUOp     = f.aluop;
        bus.op5       = f.op5;
        bus.funct3    = f.f3;
        bus.funct7_5  = f.f75;
        bus.funct7_4  = f.f74;
        bus.funct7_0  = f.f70;
        bus.out_ready = ordy;
        flush         = fl;
        reset         = rs;
        @(negedge clk);
        #2;
        if (iv && bus.in_ready) begin
            e = ref_model(f);
            e.edge_n = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        fld_t z;
        z = '{2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < n; i++) drive(1'b0, z, ordy, 1'b0, 1'b0);
    endtask

    function automatic fld_t rnd_fld();
        fld_t f;
        f.aluop = 2'($urandom_range(0, 3));
        f.op5   = 1'($urandom);
        f.f3    = 3'($urandom);
        f.f75   = 1'($urandom);
        f.f74   = 1'($urandom);
        f.f70   = 1'($urandom);
        return f;
    endfunction

    // Monitor: compares DUT against the queue front every cycle
    always @(negedge clk) begin
        bit ev, eb, er;
        int n, l;
        if (mon_en) begin
            ev = 1'b0; eb = 1'b0;
            if (q.size() > 0) begin
                n  = q[0].edge_n;
                l  = q[0].lat;
                ev = (cyc >= n + l - 1);
                eb = (cyc >= n) && (cyc <= n + l - 2);
            end
            er = !reset && !flush && (q.size() == 0 || (ev && bus.out_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            chk("mdu_busy",  32'(bus.mdu_busy),  32'(eb));
            chk("in_ready",  32'(bus.in_ready),  32'(er));
            if (ev) begin
                chk("ALUControl", 32'(bus.ALUControl), 32'(q[0].ctrl));
                chk("load_store", 32'(bus.load_store), 32'(q[0].ls));
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        fld_t f;
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ALUOp = 2'd0; bus.op5 = 1'b0;
        bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.funct7_4 = 1'b0; bus.funct7_0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   32'(bus.in_ready), 0);
        chk("rst_out_valid",  32'(bus.out_valid), 0);
        chk("rst_mdu_busy",   32'(bus.mdu_busy), 0);
        chk("rst_ALUControl", 32'(bus.ALUControl), 0);
        chk("rst_load_store", 32'(bus.load_store), 0);
        mon_en = 1'b1;
        idle(1, 1'b1);

        // load, funct3=100 -> load_store 011 one edge later
        f = '{2'd0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
        drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        chk("lw_valid", 32'(bus.out_valid), 1);
        chk("lw_ctrl",  32'(bus.ALUControl), 0);
        chk("lw_ls",    32'(bus.load_store), 3);
        idle(2, 1'b1);

        // back-to-back subtract then add
        f = '{2'd2, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        f.op5 = 1'b0;
        for (int i = 0; i < 2; i++) drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        chk("b2b_add_ctrl", 32'(bus.ALUControl), 0);
        idle(2, 1'b1);

        // divide op
        f = '{2'd2, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        idle(DIV_L + 4, 1'b1);

        // backpressure: held output stable while inputs churn
        f = '{2'd2, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
        drive(1'b1, f, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, rnd_fld(), 1'b0, 1'b0, 1'b0);
        chk("stall_ctrl", 32'(bus.ALUControl), 32'd10);
        idle(3, 1'b1);

        // flush mid-divide
        f = '{2'd2, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        idle(9, 1'b1);
        drive(1'b0, f, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk("flush_busy",  32'(bus.mdu_busy), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_ready", 32'(bus.in_ready), 1);
        idle(2, 1'b1);

        // reset mid-divide
        drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        idle(9, 1'b1);
        drive(1'b0, f, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        chk("reset_busy",  32'(bus.mdu_busy), 0);
        chk("reset_valid", 32'(bus.out_valid), 0);
        chk("reset_ctrl",  32'(bus.ALUControl), 0);
        chk("reset_ls",    32'(bus.load_store), 0);
        idle(2, 1'b1);

        // random traffic with random backpressure and rare flushes
        for (int i = 0; i < 800; i++)
            drive(1'($urandom), rnd_fld(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0), 1'b0);
        idle(DIV_L + 4, 1'b1);
        chk("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
